rat_flag_int_unit: RTL and testbench
====================================

Name: rat_flag_int_unit

Overview:
- Holds the RAT C and Z flags, their shadow copies, the interrupt-enable flag I, and the external interrupt front end (synchronizer, rising-edge detect, pending latch).
- C_FLAG and Z_FLAG feed the branch-condition logic and the PC source 2:1 mux select path.
- INT_REQ goes to the control unit.
- Sits directly upstream of those muxes; all state is updated on the CLK rising edge.

Parameters:
- SYNC_STAGES, 2, number of flops in the INT_IN synchronizer chain (legal values 2..4).

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-high reset.
- ALU_C  input  1  carry result from the ALU.
- ALU_Z  input  1  zero result from the ALU.
- FLG_LD_SEL  input  1  source for flag loads: 0 = ALU_C/ALU_Z, 1 = shadow flags.
- FLG_C_LD  input  1  load C from the selected source.
- FLG_Z_LD  input  1  load Z from the selected source.
- FLG_C_SET  input  1  force C to 1.
- FLG_C_CLR  input  1  force C to 0.
- FLG_SHAD_LD  input  1  copy the current C and Z into SHAD_C and SHAD_Z.
- I_SET  input  1  set the interrupt-enable flag I.
- I_CLR  input  1  clear the interrupt-enable flag I.
- INT_IN  input  1  asynchronous external interrupt line.
- INT_ACK  input  1  control unit is entering the ISR this cycle.
- C_FLAG  output  1  registered C.
- Z_FLAG  output  1  registered Z.
- I_FLAG  output  1  registered interrupt enable.
- INT_PEND  output  1  registered pending-interrupt latch.
- INT_REQ  output  1  interrupt request to the control unit.

Behaviour:
- Reset (async, RST=1): C, Z, SHAD_C, SHAD_Z, I, pending and all synchronizer/edge flops are 0. All outputs read 0 while RST is high and on the first edge after release.
- C update priority per edge: FLG_C_SET > FLG_C_CLR > FLG_C_LD > hold.
- Z update: FLG_Z_LD loads from the selected source; otherwise hold.
- Load source mux: FLG_LD_SEL=0 selects ALU_C/ALU_Z; FLG_LD_SEL=1 selects SHAD_C/SHAD_Z.
- Shadow load: FLG_SHAD_LD captures the pre-edge C and Z.
  - If issued together with a shadow restore (FLG_LD_SEL=1 with C_LD/Z_LD), the flags take the old shadow values and the shadow takes the old flags (swap, no race).
- I flag priority: INT_ACK > I_CLR > I_SET > hold. I_SET and I_CLR in the same cycle leave I=0.
- Synchronizer: INT_IN passes through a SYNC_STAGES flop chain to produce sync_q. A further flop holds sync_d.
- Edge detect: rise = sync_q & ~sync_d. Only 0→1 transitions count; a level held high does not retrigger.
- Latency: INT_IN rising before edge k gives rise=1 after edge k+SYNC_STAGES-1. INT_PEND goes to 1 on the following edge, i.e. SYNC_STAGES+1 edges after INT_IN rises.
- Pending latch priority: rise > INT_ACK > hold.
  - rise and INT_ACK in the same cycle leave pending=1; a new edge is never lost.
- INT_REQ = INT_PEND & I_FLAG, combinational from registered state only, so it is glitch-free.
- Interrupts while I=0 are latched in pending and raise INT_REQ once I_SET is applied.
- INT_ACK while pending=0 clears I only.
- Reset asserted mid-operation discards any pending interrupt and any edge in flight through the synchronizer.

Test Plan:
1. Reset: hold RST=1 with INT_IN=1, ALU_C=1 and all loads active -> every output reads 0. Release RST with INT_IN still 1 -> INT_PEND rises 3 edges later (SYNC_STAGES=2), since the synchronizer was reset to 0.
2. Flag priority: C=0 initially; FLG_C_SET=1, FLG_C_CLR=1, FLG_C_LD=1, ALU_C=0 -> C=1. Next cycle FLG_C_CLR=1, FLG_C_LD=1, ALU_C=1 -> C=0. Next cycle FLG_Z_LD=1, ALU_Z=1 -> Z=1, C unchanged at 0.
3. Shadow swap: C=1, Z=0, SHAD_C=0, SHAD_Z=1; apply FLG_SHAD_LD=1, FLG_LD_SEL=1, C_LD=1, Z_LD=1 for one edge -> C=0, Z=1, SHAD_C=1, SHAD_Z=0.
4. Masked interrupt: I=0; pulse INT_IN high for 1 cycle -> INT_PEND=1 after 3 edges, INT_REQ stays 0. Pulse I_SET -> INT_REQ=1 the same cycle I_FLAG goes to 1. Pulse INT_ACK -> INT_PEND=0, I_FLAG=0, INT_REQ=0.
5. Level vs edge: hold INT_IN=1 for 20 cycles; ACK the first request -> no second INT_PEND. Drop INT_IN to 0 for 3 cycles, then raise it -> INT_PEND=1 again, 3 edges after the rise.
6. Collision: arrange rise=1 in the same cycle as INT_ACK=1, with I_SET=1 also asserted -> INT_PEND stays 1, I_FLAG=0, INT_REQ=0. A subsequent I_SET re-raises INT_REQ.

Source files
------------

// File: rtl/rat_flag_int_unit.sv
// RAT flag and interrupt front end: C/Z flags with shadow copies, interrupt-enable I,
// and the INT_IN synchronizer, rising-edge detector and pending latch feeding INT_REQ.
module rat_flag_int_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic FLG_LD_SEL,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_IN,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_PEND,
    output logic INT_REQ
);

    logic                   r_c;
    logic                   r_z;
    logic                   r_shad_c;
    logic                   r_shad_z;
    logic                   r_i;
    logic                   r_pend;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    logic                   w_src_c;
    logic                   w_src_z;
    logic                   w_sync_q;
    logic                   w_rise;

    assign w_src_c  = FLG_LD_SEL ? r_shad_c : ALU_C;
    assign w_src_z  = FLG_LD_SEL ? r_shad_z : ALU_Z;
    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync_q & ~r_sync_d;

    // Shadow captures pre-edge flags while flags read pre-edge shadow, so save+restore is a clean swap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_shad_c <= 1'b0;
            r_shad_z <= 1'b0;
        end else begin
            if (FLG_C_SET)
                r_c <= 1'b1;
            else if (FLG_C_CLR)
                r_c <= 1'b0;
            else if (FLG_C_LD)
                r_c <= w_src_c;

            if (FLG_Z_LD)
                r_z <= w_src_z;

            if (FLG_SHAD_LD) begin
                r_shad_c <= r_c;
                r_shad_z <= r_z;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_i <= 1'b0;
        else if (INT_ACK)
            r_i <= 1'b0;
        else if (I_CLR)
            r_i <= 1'b0;
        else if (I_SET)
            r_i <= 1'b1;
    end

    // A fresh edge wins over an acknowledge so that no interrupt is dropped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], INT_IN};
            r_sync_d <= w_sync_q;
            if (w_rise)
                r_pend <= 1'b1;
            else if (INT_ACK)
                r_pend <= 1'b0;
        end
    end

    assign C_FLAG   = r_c;
    assign Z_FLAG   = r_z;
    assign I_FLAG   = r_i;
    assign INT_PEND = r_pend;
    assign INT_REQ  = r_pend & r_i;

endmodule

// File: tb/tb_rat_flag_int_unit.sv
// Directed self-checking bench for rat_flag_int_unit with SYNC_STAGES=2.
module tb_rat_flag_int_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ALU_C = 1'b0, ALU_Z = 1'b0, FLG_LD_SEL = 1'b0;
    logic FLG_C_LD = 1'b0, FLG_Z_LD = 1'b0, FLG_C_SET = 1'b0, FLG_C_CLR = 1'b0;
    logic FLG_SHAD_LD = 1'b0, I_SET = 1'b0, I_CLR = 1'b0;
    logic INT_IN = 1'b0, INT_ACK = 1'b0;
    logic C_FLAG, Z_FLAG, I_FLAG, INT_PEND, INT_REQ;

    int errors = 0;
    int checks = 0;

    rat_flag_int_unit #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .ALU_C(ALU_C), .ALU_Z(ALU_Z), .FLG_LD_SEL(FLG_LD_SEL),
        .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
        .FLG_SHAD_LD(FLG_SHAD_LD), .I_SET(I_SET), .I_CLR(I_CLR), .INT_IN(INT_IN),
        .INT_ACK(INT_ACK), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .INT_PEND(INT_PEND), .INT_REQ(INT_REQ)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ctrl();
        ALU_C = 0; ALU_Z = 0; FLG_LD_SEL = 0; FLG_C_LD = 0; FLG_Z_LD = 0;
        FLG_C_SET = 0; FLG_C_CLR = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    endtask

    task automatic test_reset();
        logic [4:0] outs;
        RST = 1; INT_IN = 1; ALU_C = 1; ALU_Z = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        FLG_C_SET = 1; FLG_SHAD_LD = 1; I_SET = 1;
        tick(); tick();
        outs = {C_FLAG, Z_FLAG, I_FLAG, INT_PEND, INT_REQ};
        checks++;
        if (outs !== 5'b0) begin
            errors++; $display("FAIL reset_hold outs=%b expected=%b", outs, 5'b0);
        end
        clear_ctrl();
        RST = 0;
        tick();
        outs = {C_FLAG, Z_FLAG, I_FLAG, INT_PEND, INT_REQ};
        checks++;
        if (outs !== 5'b0) begin
            errors++; $display("FAIL reset_first_edge outs=%b expected=%b", outs, 5'b0);
        end
        tick();
        checks++;
        if (INT_PEND !== 1'b0) begin
            errors++; $display("FAIL reset_pend_edge2 got=%b expected=0", INT_PEND);
        end
        tick();
        checks++;
        if (INT_PEND !== 1'b1) begin
            errors++; $display("FAIL reset_pend_edge3 got=%b expected=1", INT_PEND);
        end
        INT_IN = 0; INT_ACK = 1;
        tick();
        INT_ACK = 0;
        checks++;
        if (INT_PEND !== 1'b0) begin
            errors++; $display("FAIL reset_ack_clear got=%b expected=0", INT_PEND);
        end
    endtask

    task automatic test_flag_priority();
        FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1; ALU_C = 0;
        tick();
        clear_ctrl();
        checks++;
        if (C_FLAG !== 1'b1) begin
            errors++; $display("FAIL prio_set got=%b expected=1", C_FLAG);
        end
        FLG_C_CLR = 1; FLG_C_LD = 1; ALU_C = 1;
        tick();
        clear_ctrl();
        checks++;
        if (C_FLAG !== 1'b0) begin
            errors++; $display("FAIL prio_clr got=%b expected=0", C_FLAG);
        end
        FLG_Z_LD = 1; ALU_Z = 1; ALU_C = 1;
        tick();
        clear_ctrl();
        checks++;
        if ({C_FLAG, Z_FLAG} !== 2'b01) begin
            errors++; $display("FAIL prio_zld cz=%b expected=01", {C_FLAG, Z_FLAG});
        end
    endtask

    task automatic test_shadow_swap();
        // shadow <= (C=0, Z=1)
        FLG_C_LD = 1; FLG_Z_LD = 1; ALU_C = 0; ALU_Z = 1;
        tick();
        clear_ctrl();
        FLG_SHAD_LD = 1;
        tick();
        clear_ctrl();
        FLG_C_LD = 1; FLG_Z_LD = 1; ALU_C = 1; ALU_Z = 0;
        tick();
        clear_ctrl();
        checks++;
        if ({C_FLAG, Z_FLAG} !== 2'b10) begin
            errors++; $display("FAIL swap_setup cz=%b expected=10", {C_FLAG, Z_FLAG});
        end
        FLG_SHAD_LD = 1; FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1; ALU_C = 1; ALU_Z = 1;
        tick();
        clear_ctrl();
        checks++;
        if ({C_FLAG, Z_FLAG} !== 2'b01) begin
            errors++; $display("FAIL swap_flags cz=%b expected=01", {C_FLAG, Z_FLAG});
        end
        // restore from shadow only, exposing what the swap stored
        FLG_LD_SEL = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        tick();
        clear_ctrl();
        checks++;
        if ({C_FLAG, Z_FLAG} !== 2'b10) begin
            errors++; $display("FAIL swap_shadow cz=%b expected=10", {C_FLAG, Z_FLAG});
        end
    endtask

    task automatic test_masked_int();
        INT_IN = 1;
        tick();
        INT_IN = 0;
        tick();
        checks++;
        if (INT_PEND !== 1'b0) begin
            errors++; $display("FAIL masked_early got=%b expected=0", INT_PEND);
        end
        tick();
        checks++;
        if ({INT_PEND, INT_REQ} !== 2'b10) begin
            errors++; $display("FAIL masked_pend pend_req=%b expected=10", {INT_PEND, INT_REQ});
        end
        tick(); tick();
        checks++;
        if ({INT_PEND, INT_REQ} !== 2'b10) begin
            errors++; $display("FAIL masked_hold pend_req=%b expected=10", {INT_PEND, INT_REQ});
        end
        I_SET = 1;
        tick();
        I_SET = 0;
        checks++;
        if ({I_FLAG, INT_REQ} !== 2'b11) begin
            errors++; $display("FAIL unmask i_req=%b expected=11", {I_FLAG, INT_REQ});
        end
        INT_ACK = 1;
        tick();
        INT_ACK = 0;
        checks++;
        if ({INT_PEND, I_FLAG, INT_REQ} !== 3'b000) begin
            errors++; $display("FAIL masked_ack pend_i_req=%b expected=000", {INT_PEND, I_FLAG, INT_REQ});
        end
    endtask

    task automatic test_level_vs_edge();
        int retrig = 0;
        INT_IN = 1;
        tick(); tick(); tick();
        checks++;
        if (INT_PEND !== 1'b1) begin
            errors++; $display("FAIL level_first got=%b expected=1", INT_PEND);
        end
        INT_ACK = 1;
        tick();
        INT_ACK = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (INT_PEND !== 1'b0) retrig++;
        end
        checks++;
        if (retrig != 0) begin
            errors++; $display("FAIL level_retrigger cycles_pending=%0d expected=0", retrig);
        end
        INT_IN = 0;
        tick(); tick(); tick();
        INT_IN = 1;
        tick(); tick();
        checks++;
        if (INT_PEND !== 1'b0) begin
            errors++; $display("FAIL level_rise_early got=%b expected=0", INT_PEND);
        end
        tick();
        checks++;
        if ({INT_PEND, INT_REQ} !== 2'b10) begin
            errors++; $display("FAIL level_rise_again pend_req=%b expected=10", {INT_PEND, INT_REQ});
        end
    endtask

    task automatic test_collision();
        // pending is still 1 from the previous scenario
        INT_IN = 0; I_SET = 1;
        tick();
        I_SET = 0;
        checks++;
        if (INT_REQ !== 1'b1) begin
            errors++; $display("FAIL coll_pre_req got=%b expected=1", INT_REQ);
        end
        tick(); tick();
        INT_IN = 1;
        tick(); tick();
        INT_ACK = 1; I_SET = 1;
        tick();
        INT_ACK = 0; I_SET = 0;
        checks++;
        if ({INT_PEND, I_FLAG, INT_REQ} !== 3'b100) begin
            errors++; $display("FAIL collision pend_i_req=%b expected=100", {INT_PEND, I_FLAG, INT_REQ});
        end
        I_SET = 1;
        tick();
        I_SET = 0;
        checks++;
        if (INT_REQ !== 1'b1) begin
            errors++; $display("FAIL coll_reraise got=%b expected=1", INT_REQ);
        end
        I_SET = 1; I_CLR = 1;
        tick();
        clear_ctrl();
        checks++;
        if ({I_FLAG, INT_REQ} !== 2'b00) begin
            errors++; $display("FAIL set_clr_same i_req=%b expected=00", {I_FLAG, INT_REQ});
        end
        INT_ACK = 1;
        tick();
        INT_ACK = 0;
    endtask

    task automatic test_midop_reset();
        INT_IN = 0;
        tick(); tick(); tick();
        I_SET = 1; FLG_C_SET = 1;
        tick();
        clear_ctrl();
        INT_IN = 1;
        tick();
        #2 RST = 1;
        #1;
        checks++;
        if ({C_FLAG, I_FLAG, INT_PEND} !== 3'b000) begin
            errors++; $display("FAIL async_reset c_i_pend=%b expected=000", {C_FLAG, I_FLAG, INT_PEND});
        end
        INT_IN = 0;
        tick();
        RST = 0;
        tick(); tick(); tick(); tick();
        checks++;
        if (INT_PEND !== 1'b0) begin
            errors++; $display("FAIL reset_flush got=%b expected=0", INT_PEND);
        end
    endtask

    initial begin
        test_reset();
        test_flag_priority();
        test_shadow_swap();
        test_masked_int();
        test_level_vs_edge();
        test_collision();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
